// File: rtl/servant_sleep_ctrl.sv
// rtl/servant_sleep_ctrl.sv - sleep/wake sequencer gating the SERV wb_clk enable
// Optional SERVANT_SLEEP_STATS_EN adds GATED cycle and entry counters.
module servant_sleep_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int WAKE_CYCLES  = 8,
  parameter int CNT_W        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sleep_req,
  input  logic        i_wakeup_req,
  input  logic        i_ext_irq,
  input  logic        i_wb_cyc,
  output logic        o_clk_en,
  output logic        o_awake,
`ifdef SERVANT_SLEEP_STATS_EN
  output logic [31:0] o_sleep_cnt,
  output logic [15:0] o_sleep_events,
`endif
  output logic        o_sleeping
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255 || DRAIN_CYCLES > (1 << CNT_W) ||
      WAKE_CYCLES < 1 || WAKE_CYCLES > 255 || WAKE_CYCLES > (1 << CNT_W)) begin : g_param_err
    $error("servant_sleep_ctrl: DRAIN_CYCLES/WAKE_CYCLES out of range for CNT_W");
  end

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_GATED, S_WAKE} state_t;

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wake_pend;
  logic             r_clk_en;
  logic             r_awake;
  logic             r_sleeping;

  logic w_wake_src;
  logic w_wake;
  logic w_gate_entry;

  assign w_wake_src   = i_wakeup_req | i_ext_irq;
  assign w_wake       = w_wake_src | r_wake_pend;
  assign w_gate_entry = (r_state == S_DRAIN) && !w_wake && !i_wb_cyc && (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_wake_pend <= 1'b0;
      r_clk_en    <= 1'b1;
      r_awake     <= 1'b1;
      r_sleeping  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          // A wake in the same cycle as the sleep request wins.
          if (i_sleep_req && !w_wake) begin
            r_state <= S_DRAIN;
            r_cnt   <= DRAIN_LOAD;
            r_awake <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_wake_pend <= r_wake_pend | w_wake_src;
          if (w_wake) begin
            r_state     <= S_RUN;
            r_awake     <= 1'b1;
            r_wake_pend <= 1'b0;
          end else if (i_wb_cyc) begin
            r_cnt <= DRAIN_LOAD;
          end else if (r_cnt == '0) begin
            r_state    <= S_GATED;
            r_clk_en   <= 1'b0;
            r_sleeping <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GATED: begin
          r_wake_pend <= r_wake_pend | w_wake_src;
          if (w_wake) begin
            r_state     <= S_WAKE;
            r_cnt       <= WAKE_LOAD;
            r_clk_en    <= 1'b1;
            r_sleeping  <= 1'b0;
            r_wake_pend <= 1'b0;
          end
        end
        S_WAKE: begin
          // Clock is running but still settling; requests are absorbed here.
          if (r_cnt == '0) begin
            r_state <= S_RUN;
            r_awake <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= S_RUN;
          r_clk_en   <= 1'b1;
          r_awake    <= 1'b1;
          r_sleeping <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERVANT_SLEEP_STATS_EN
  logic [31:0] r_sleep_cnt;
  logic [15:0] r_sleep_events;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sleep_cnt    <= '0;
      r_sleep_events <= '0;
    end else begin
      if (r_state == S_GATED && r_sleep_cnt != 32'hFFFF_FFFF)
        r_sleep_cnt <= r_sleep_cnt + 32'd1;
      if (w_gate_entry)
        r_sleep_events <= r_sleep_events + 16'd1;
    end
  end

  assign o_sleep_cnt    = r_sleep_cnt;
  assign o_sleep_events = r_sleep_events;
`endif

  assign o_clk_en   = r_clk_en;
  assign o_awake    = r_awake;
  assign o_sleeping = r_sleeping;

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// tb/tb_servant_sleep_ctrl.sv - directed and random checks of servant_sleep_ctrl
module tb_servant_sleep_ctrl;
  localparam int DRAIN = 4;
  localparam int WAKE  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sleep_req = 1'b0, wakeup_req = 1'b0, ext_irq = 1'b0, wb_cyc = 1'b0;
  logic clk_en, awake, sleeping;
`ifdef SERVANT_SLEEP_STATS_EN
  logic [31:0] sleep_cnt;
  logic [15:0] sleep_events;
`endif

  int total = 0;
  int bad   = 0;

  // Reference: boolean phase flags plus idle-streak and settle-age counts.
  bit draining, gated, waking;
  int idle_streak, wake_age;
  longint m_sleep_cycles;
  int m_entries;

  servant_sleep_ctrl #(.DRAIN_CYCLES(DRAIN), .WAKE_CYCLES(WAKE), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req), .i_wakeup_req(wakeup_req),
    .i_ext_irq(ext_irq), .i_wb_cyc(wb_cyc), .o_clk_en(clk_en), .o_awake(awake),
`ifdef SERVANT_SLEEP_STATS_EN
    .o_sleep_cnt(sleep_cnt), .o_sleep_events(sleep_events),
`endif
    .o_sleeping(sleeping)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    draining = 0; gated = 0; waking = 0;
    idle_streak = 0; wake_age = 0;
    m_sleep_cycles = 0; m_entries = 0;
  endtask

  task automatic model_edge(input bit s, input bit w, input bit irq, input bit c);
    bit wake_now;
    wake_now = w | irq;
    if (gated && m_sleep_cycles < 64'hFFFF_FFFF) m_sleep_cycles++;
    if (gated) begin
      if (wake_now) begin gated = 0; waking = 1; wake_age = 0; end
    end else if (waking) begin
      wake_age++;
      if (wake_age == WAKE) waking = 0;
    end else if (draining) begin
      if (wake_now) draining = 0;
      else if (c) idle_streak = 0;
      else begin
        idle_streak++;
        if (idle_streak == DRAIN) begin draining = 0; gated = 1; m_entries++; end
      end
    end else if (s && !wake_now) begin
      draining = 1; idle_streak = 0;
    end
  endtask

  task automatic step(input string tag, input bit s, input bit w, input bit irq, input bit c);
    sleep_req = s; wakeup_req = w; ext_irq = irq; wb_cyc = c;
    @(posedge clk);
    model_edge(s, w, irq, c);
    #1;
    chk({tag, ".clk_en"},   clk_en,   !gated);
    chk({tag, ".awake"},    awake,    !(draining || gated || waking));
    chk({tag, ".sleeping"}, sleeping, gated);
`ifdef SERVANT_SLEEP_STATS_EN
    chk32({tag, ".scnt"}, sleep_cnt, m_sleep_cycles[31:0]);
    chk32({tag, ".sevt"}, {16'd0, sleep_events}, 32'(m_entries % 65536));
`endif
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.clk_en", clk_en, 1'b1);
    chk("rst.awake", awake, 1'b1);
    chk("rst.sleeping", sleeping, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Idle-bus sleep: gate closes DRAIN+1 edges after the request.
    step("sl_req", 1, 0, 0, 0);
    for (int i = 2; i <= 5; i++) begin
      step("sl_drain", 0, 0, 0, 0);
      chk("sl_en_timing", clk_en, (i == 5) ? 1'b0 : 1'b1);
    end
    chk("sl_sleeping", sleeping, 1'b1);

    // Async reset while GATED, observed before any clock edge.
    step("gated_hold", 1, 0, 0, 0);
    rst = 1'b1;
    #2;
    chk("arst.clk_en", clk_en, 1'b1);
    chk("arst.awake", awake, 1'b1);
    chk("arst.sleeping", sleeping, 1'b0);
    model_reset();
    @(negedge clk) rst = 1'b0;

    // Busy bus holds off gating until DRAIN idle cycles follow it.
    step("busy_req", 1, 0, 0, 0);
    for (int i = 2; i <= 11; i++) begin
      step("busy_cyc", 0, 0, 0, 1);
      chk("busy_en_hi", clk_en, 1'b1);
    end
    for (int i = 12; i <= 15; i++) begin
      step("busy_idle", 0, 0, 0, 0);
      chk("busy_en_timing", clk_en, (i == 15) ? 1'b0 : 1'b1);
    end

    // Wake by ext irq: clock back in 1 edge, awake after WAKE+1 edges.
    step("gated_a", 0, 0, 0, 0);
    step("wake_irq", 0, 0, 1, 0);
    chk("wake_en", clk_en, 1'b1);
    chk("wake_awake0", awake, 1'b0);
    for (int i = 2; i <= 9; i++) begin
      step("wake_settle", (i == 4), (i == 5), 0, 0);
      chk("wake_awake_timing", awake, (i == 9) ? 1'b1 : 1'b0);
    end

    // Sleep and wake together in RUN: wake wins.
    step("race_run", 1, 1, 0, 0);
    chk("race_run_awake", awake, 1'b1);
    step("race_run2", 0, 0, 0, 0);
    chk("race_run_en", clk_en, 1'b1);

    // Wake during DRAIN aborts back to RUN.
    step("race_drain_req", 1, 0, 0, 0);
    chk("race_drain_a0", awake, 1'b0);
    step("race_drain_wk", 0, 1, 0, 0);
    chk("race_drain_a1", awake, 1'b1);
    chk("race_drain_en", clk_en, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      step("rand",
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
